// File: rtl/sensor_pkg.sv
// Shared definitions for the sensor input path: channel count, default
// debounce timing and the counter-width helper used by every counter.
package sensor_pkg;

  localparam int SENSOR_NUM_CH          = 3;
  localparam int SENSOR_TICK_DIV        = 1;
  localparam int SENSOR_DEBOUNCE_TICKS  = 4;

  // Bits needed to count 0..n-1, never less than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One sensor channel: 2-flop synchroniser, persistence counter, accepted
// (clean) level and registered one-cycle rise/fall pulses.
module debounce_channel
  import sensor_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = SENSOR_DEBOUNCE_TICKS
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena_i,
  input  logic tick_i,
  input  logic raw_i,
  output logic clean_o,
  output logic rise_o,
  output logic fall_o,
  output logic settled_o
);

  localparam int CW = cnt_width(DEBOUNCE_TICKS);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_TICKS - 1);

  logic          sync1_q, sync2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          clean_q, clean_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;

  // Synchroniser runs regardless of ena so the settled view stays current.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
    end
  end

  // Any return to the clean level restarts the count; otherwise count ticks
  // and accept the new level on the last one. Pulses coincide with acceptance.
  always_comb begin
    cnt_d   = cnt_q;
    clean_d = clean_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (sync2_q == clean_q) begin
      cnt_d = '0;
    end else if (tick_i && ena_i) begin
      if (cnt_q == CNT_LAST) begin
        clean_d = sync2_q;
        cnt_d   = '0;
        rise_d  = sync2_q;
        fall_d  = ~sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Debounce state and pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      clean_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign clean_o   = clean_q;
  assign rise_o    = rise_q;
  assign fall_o    = fall_q;
  assign settled_o = (sync2_q == clean_q);

endmodule

// File: rtl/sensor_debounce.sv
// Input conditioning for the stress_sensor inputs: shared tick prescaler,
// one debounce_channel per sensor and an all-channels-settled flag.
module sensor_debounce
  import sensor_pkg::*;
#(
  parameter int NUM_CH         = SENSOR_NUM_CH,
  parameter int TICK_DIV       = SENSOR_TICK_DIV,
  parameter int DEBOUNCE_TICKS = SENSOR_DEBOUNCE_TICKS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [NUM_CH-1:0] sensor_raw,
  output logic [NUM_CH-1:0] sensor_clean,
  output logic [NUM_CH-1:0] sensor_rise,
  output logic [NUM_CH-1:0] sensor_fall,
  output logic              stable
);

  localparam int TW = cnt_width(TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  logic [TW-1:0]     tick_cnt_q, tick_cnt_d;
  logic              tick;
  logic [NUM_CH-1:0] settled;

  // Tick fires on the last prescaler count; with TICK_DIV=1 it is ena itself.
  always_comb begin
    tick       = ena && (tick_cnt_q == TICK_LAST);
    tick_cnt_d = tick_cnt_q;
    if (ena) begin
      tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    end
  end

  // Prescaler register; frozen while ena is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .ena_i    (ena),
      .tick_i   (tick),
      .raw_i    (sensor_raw[i]),
      .clean_o  (sensor_clean[i]),
      .rise_o   (sensor_rise[i]),
      .fall_o   (sensor_fall[i]),
      .settled_o(settled[i])
    );
  end

  assign stable = &settled;

endmodule

// File: tb/tb_sensor_debounce.sv
// Bench for sensor_debounce: a default instance (TICK_DIV=1) and a
// prescaled instance (TICK_DIV=4) checked against a behavioural model.
module tb_sensor_debounce;

  localparam int DT = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [2:0] raw_a = '0, raw_p = '0;
  logic [2:0] clean_a, rise_a, fall_a, clean_p, rise_p, fall_p;
  logic       stable_a, stable_p;
  logic [9:0] obs_a, obs_p;

  int checks = 0;
  int errors = 0;

  // Clock
  always #5 clk = ~clk;

  sensor_debounce #(.NUM_CH(3), .TICK_DIV(1), .DEBOUNCE_TICKS(DT)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .sensor_raw(raw_a),
    .sensor_clean(clean_a), .sensor_rise(rise_a), .sensor_fall(fall_a),
    .stable(stable_a)
  );

  sensor_debounce #(.NUM_CH(3), .TICK_DIV(4), .DEBOUNCE_TICKS(DT)) dut_p (
    .clk(clk), .rst_n(rst_n), .ena(ena), .sensor_raw(raw_p),
    .sensor_clean(clean_p), .sensor_rise(rise_p), .sensor_fall(fall_p),
    .stable(stable_p)
  );

  assign obs_a = {clean_a, rise_a, fall_a, stable_a};
  assign obs_p = {clean_p, rise_p, fall_p, stable_p};

  // Reference model: the level seen two edges after sampling must disagree
  // with the accepted level for DT consecutive ticks before it is accepted.
  int         td [2] = '{1, 4};
  logic [2:0] m_s1 [2], m_s [2], m_clean [2], m_rise [2], m_fall [2];
  int         m_run [2][3];
  int         m_phase [2];

  always @(posedge clk or negedge rst_n) begin
    logic t;
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        m_s1[d] = '0; m_s[d] = '0; m_clean[d] = '0;
        m_rise[d] = '0; m_fall[d] = '0; m_phase[d] = 0;
        for (int c = 0; c < 3; c++) m_run[d][c] = 0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        t = ena && ((m_phase[d] % td[d]) == td[d] - 1);
        if (ena) m_phase[d] = m_phase[d] + 1;
        m_rise[d] = '0;
        m_fall[d] = '0;
        for (int c = 0; c < 3; c++) begin
          if (m_s[d][c] == m_clean[d][c]) begin
            m_run[d][c] = 0;
          end else if (t) begin
            m_run[d][c] = m_run[d][c] + 1;
            if (m_run[d][c] == DT) begin
              m_clean[d][c] = m_s[d][c];
              if (m_s[d][c]) m_rise[d][c] = 1'b1;
              else           m_fall[d][c] = 1'b1;
              m_run[d][c] = 0;
            end
          end
        end
        m_s[d]  = m_s1[d];
        m_s1[d] = (d == 0) ? raw_a : raw_p;
      end
    end
  end

  function automatic logic [9:0] exp_vec(input int d);
    return {m_clean[d], m_rise[d], m_fall[d], (m_s[d] == m_clean[d])};
  endfunction

  // Driver tasks
  task automatic drive(input logic [2:0] a, input logic [2:0] p);
    @(negedge clk);
    raw_a = a;
    raw_p = p;
  endtask

  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    edge_sample();
    edge_sample();
    checks += 2;
    if (obs_a !== {3'b000, 3'b000, 3'b000, 1'b1}) begin
      errors++; $display("FAIL reset_a got %b exp %b", obs_a, 10'b0000000001);
    end
    if (obs_p !== {3'b000, 3'b000, 3'b000, 1'b1}) begin
      errors++; $display("FAIL reset_p got %b exp %b", obs_p, 10'b0000000001);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_clean_step();
    int hit = 0;
    drive(3'b001, 3'b000);
    for (int e = 1; e <= 12; e++) begin
      edge_sample();
      checks += 2;
      if (obs_a !== exp_vec(0)) begin errors++; $display("FAIL step_a edge %0d got %b exp %b", e, obs_a, exp_vec(0)); end
      if (obs_p !== exp_vec(1)) begin errors++; $display("FAIL step_p edge %0d got %b exp %b", e, obs_p, exp_vec(1)); end
      if (clean_a[0] && hit == 0) begin
        hit = e;
        checks++;
        if (rise_a !== 3'b001) begin errors++; $display("FAIL step_rise got %b exp 001", rise_a); end
      end
    end
    checks++;
    if (hit != 6) begin errors++; $display("FAIL step_latency got %0d exp 6", hit); end
  endtask

  task automatic test_glitch();
    int back = 0;
    drive(3'b011, 3'b000);
    for (int e = 1; e <= 12; e++) begin
      edge_sample();
      checks += 3;
      if (obs_a !== exp_vec(0)) begin errors++; $display("FAIL glitch_a edge %0d got %b exp %b", e, obs_a, exp_vec(0)); end
      if (obs_p !== exp_vec(1)) begin errors++; $display("FAIL glitch_p edge %0d got %b exp %b", e, obs_p, exp_vec(1)); end
      if ({clean_a, rise_a, fall_a} !== {3'b001, 3'b000, 3'b000}) begin
        errors++; $display("FAIL glitch_clean edge %0d got %b exp 001000000", e, {clean_a, rise_a, fall_a});
      end
      if (e >= 4 && stable_a && back == 0) back = e;
      if (e == 3) begin
        @(negedge clk);
        raw_a = 3'b001;
      end
    end
    checks++;
    if (back != 5) begin errors++; $display("FAIL glitch_stable_edge got %0d exp 5", back); end
  endtask

  task automatic test_simultaneous();
    int hit;
    drive(3'b000, 3'b000);
    for (int e = 1; e <= 10; e++) begin
      edge_sample();
      checks++;
      if (obs_a !== exp_vec(0)) begin errors++; $display("FAIL simul_idle edge %0d got %b exp %b", e, obs_a, exp_vec(0)); end
    end
    for (int phase = 0; phase < 2; phase++) begin
      hit = 0;
      drive(phase == 0 ? 3'b111 : 3'b000, 3'b000);
      for (int e = 1; e <= 10; e++) begin
        edge_sample();
        checks++;
        if (obs_a !== exp_vec(0)) begin errors++; $display("FAIL simul_a edge %0d got %b exp %b", e, obs_a, exp_vec(0)); end
        if (hit == 0 && (rise_a != 0 || fall_a != 0)) begin
          hit = e;
          checks++;
          if ({rise_a, fall_a} !== (phase == 0 ? 6'b111000 : 6'b000111)) begin
            errors++; $display("FAIL simul_pulse phase %0d got %b", phase, {rise_a, fall_a});
          end
        end
      end
      checks++;
      if (hit != 6) begin errors++; $display("FAIL simul_latency phase %0d got %0d exp 6", phase, hit); end
    end
  endtask

  task automatic test_prescaler();
    int hit = 0;
    int pre = $urandom_range(0, 3);
    for (int e = 0; e < pre; e++) edge_sample();
    drive(3'b000, 3'b100);
    for (int e = 1; e <= 30; e++) begin
      edge_sample();
      checks++;
      if (obs_p !== exp_vec(1)) begin errors++; $display("FAIL presc_p edge %0d got %b exp %b", e, obs_p, exp_vec(1)); end
      if (clean_p[2] && hit == 0) hit = e;
    end
    checks++;
    if (hit < 15 || hit > 18) begin errors++; $display("FAIL presc_latency got %0d exp 15..18", hit); end
  endtask

  task automatic test_enable_freeze();
    int hit = 0;
    drive(3'b001, 3'b100);
    for (int e = 1; e <= 4; e++) edge_sample();
    @(negedge clk);
    ena = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      edge_sample();
      checks += 3;
      if (obs_a !== exp_vec(0)) begin errors++; $display("FAIL freeze_a edge %0d got %b exp %b", e, obs_a, exp_vec(0)); end
      if (obs_p !== exp_vec(1)) begin errors++; $display("FAIL freeze_p edge %0d got %b exp %b", e, obs_p, exp_vec(1)); end
      if ({clean_a, rise_a, fall_a} !== 9'b000000000) begin
        errors++; $display("FAIL freeze_hold edge %0d got %b exp 000000000", e, {clean_a, rise_a, fall_a});
      end
    end
    @(negedge clk);
    ena = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      edge_sample();
      checks++;
      if (obs_a !== exp_vec(0)) begin errors++; $display("FAIL resume_a edge %0d got %b exp %b", e, obs_a, exp_vec(0)); end
      if (clean_a[0] && hit == 0) hit = e;
    end
    checks++;
    if (hit != 2) begin errors++; $display("FAIL resume_latency got %0d exp 2", hit); end
  endtask

  task automatic test_reset_mid();
    int hit = 0;
    drive(3'b101, 3'b100);
    for (int e = 1; e <= 8; e++) edge_sample();
    checks++;
    if (clean_a !== 3'b101) begin errors++; $display("FAIL rstmid_pre got %b exp 101", clean_a); end
    drive(3'b000, 3'b000);
    for (int e = 1; e <= 3; e++) edge_sample();
    #1;
    rst_n = 1'b0;
    raw_a = 3'b101;
    #1;
    checks += 2;
    if (obs_a !== 10'b0000000001) begin errors++; $display("FAIL rstmid_async_a got %b exp 0000000001", obs_a); end
    if (obs_p !== 10'b0000000001) begin errors++; $display("FAIL rstmid_async_p got %b exp 0000000001", obs_p); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      edge_sample();
      checks++;
      if (obs_a !== exp_vec(0)) begin errors++; $display("FAIL rstmid_a edge %0d got %b exp %b", e, obs_a, exp_vec(0)); end
      if (rise_a != 0 && hit == 0) begin
        hit = e;
        checks++;
        if (rise_a !== 3'b101) begin errors++; $display("FAIL rstmid_rise got %b exp 101", rise_a); end
      end
    end
    checks++;
    if (hit != 6) begin errors++; $display("FAIL rstmid_latency got %0d exp 6", hit); end
  endtask

  task automatic test_random();
    int hold;
    for (int seg = 0; seg < 120; seg++) begin
      drive(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      ena = ($urandom_range(0, 7) != 0);
      hold = $urandom_range(1, 10);
      for (int e = 0; e < hold; e++) begin
        edge_sample();
        checks += 2;
        if (obs_a !== exp_vec(0)) begin errors++; $display("FAIL random_a seg %0d got %b exp %b", seg, obs_a, exp_vec(0)); end
        if (obs_p !== exp_vec(1)) begin errors++; $display("FAIL random_p seg %0d got %b exp %b", seg, obs_p, exp_vec(1)); end
      end
    end
    @(negedge clk);
    ena = 1'b1;
  endtask

  initial begin
    test_reset();
    test_clean_step();
    test_glitch();
    test_simultaneous();
    test_prescaler();
    test_enable_freeze();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
